// File: rtl/pingpang_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pingpang_pkg
//  Purpose  : Shared types and constants for the ping-pong frame controller.
//  Revision : 1.0 - initial release
// ============================================================================
package pingpang_pkg;

   // Width of the frame/stall statistics counters and the word counter.
   localparam int CNT_W      = 16;

   // Default sample width; must match the ping-pong buffer data width.
   localparam int DATA_W_DEF = 16;

   // Write-side controller states.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FILL      = 2'd1,
      ST_WAIT_CONS = 2'd2,
      ST_SWAP      = 2'd3
   } state_e;

endpackage : pingpang_pkg
`default_nettype wire

// File: rtl/pingpang_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pingpang_sat_cnt
//  Purpose  : CNT_W-bit event counter with synchronous clear; SATURATE=1
//             sticks at all-ones, SATURATE=0 wraps to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pingpang_sat_cnt
   import pingpang_pkg::*;
#(
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment unless pinned at the top.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         if (!(SATURATE && (cnt_q == {CNT_W{1'b1}}))) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : pingpang_sat_cnt
`default_nettype wire

// File: rtl/pingpang_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pingpang_frame_ctrl
//  Purpose  : Write-side controller for the ping-pong buffer. Forwards
//             accepted words as registered writes, frames them, and pulses
//             switch once the consumer has released the previous buffer.
//  Config   : PINGPANG_FRAME_CTRL_STATS_EN builds frame_cnt / stall_cnt;
//             when undefined both outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pingpang_frame_ctrl
   import pingpang_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic [DATA_W-1:0] buf_data,
   output logic              buf_wr,
   output logic              switch,
   input  logic              cons_ready,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   state_e            state_q,    state_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic              s_ready_q,  s_ready_d;
   logic [DATA_W-1:0] buf_data_q, buf_data_d;
   logic              buf_wr_q,   buf_wr_d;
   logic              switch_q,   switch_d;
   logic              accept;
   logic              frame_end;

   assign accept    = s_valid & s_ready_q;
   assign frame_end = accept & (s_last | (word_cnt_q == LAST_IDX));

   // Next-state and registered-output decode. s_ready is registered from
   // the next state so it is low in reset and rises one cycle after release.
   // switch is registered off SWAP so it lands after the last buf_wr cycle.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      buf_data_d = buf_data_q;
      buf_wr_d   = accept;
      switch_d   = (state_q == ST_SWAP);
      if (accept) begin
         buf_data_d = s_data;
      end
      case (state_q)
         ST_IDLE, ST_FILL: begin
            if (accept) begin
               word_cnt_d = word_cnt_q + 1'b1;
               if (frame_end) begin
                  state_d = cons_ready ? ST_SWAP : ST_WAIT_CONS;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         ST_WAIT_CONS: begin
            if (cons_ready) begin
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            word_cnt_d = '0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
         end
      endcase
      s_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
   end

   // Controller state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= '0;
         s_ready_q  <= 1'b0;
         buf_data_q <= '0;
         buf_wr_q   <= 1'b0;
         switch_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         s_ready_q  <= s_ready_d;
         buf_data_q <= buf_data_d;
         buf_wr_q   <= buf_wr_d;
         switch_q   <= switch_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign buf_data = buf_data_q;
   assign buf_wr   = buf_wr_q;
   assign switch   = switch_q;

`ifdef PINGPANG_FRAME_CTRL_STATS_EN
   // Frames completed (wrapping) and source-stall cycles (saturating).
   pingpang_sat_cnt #(
      .SATURATE (1'b0)
   ) u_frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (state_q == ST_SWAP),
      .clr   (1'b0),
      .cnt   (frame_cnt)
   );

   pingpang_sat_cnt #(
      .SATURATE (1'b1)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (s_valid & ~s_ready_q),
      .clr   (1'b0),
      .cnt   (stall_cnt)
   );
`else
   assign frame_cnt = '0;
   assign stall_cnt = '0;
`endif

endmodule : pingpang_frame_ctrl
`default_nettype wire
